// File: rtl/fft16_pkg.sv
// Shared state type, sizes and twiddle/addressing helpers for the 16-point FFT.
// Build option FFT_OUT_DIGITREV_EN (see top) does not affect this package.
package fft16_pkg;
   localparam int N     = 16;
   localparam int RADIX = 4;

   typedef enum logic [2:0] {IDLE, LOAD, STG1, STG2, UNLOAD} state_t;

   // cos(pi*i/8), i=0..3, held in Q1.30 and rounded to Q2.(tww-2)
   function automatic int tw_q(input int i, input int tww);
      int c30;
      int sh;
      case (i)
         0:       c30 = 1073741824;
         1:       c30 = 992008095;
         2:       c30 = 759250125;
         3:       c30 = 410903207;
         default: c30 = 0;
      endcase
      sh = 32 - tww;
      if (sh > 0) return (c30 + (1 << (sh - 1))) >>> sh;
      return c30;
   endfunction

   function automatic int tw_cos(input int k, input int tww);
      case (k)
         0:       return tw_q(0, tww);
         1:       return tw_q(1, tww);
         2:       return tw_q(2, tww);
         3:       return tw_q(3, tww);
         5:       return -tw_q(3, tww);
         6:       return -tw_q(2, tww);
         7:       return -tw_q(1, tww);
         8:       return -tw_q(0, tww);
         9:       return -tw_q(1, tww);
         default: return 0;
      endcase
   endfunction

   function automatic int tw_sin(input int k, input int tww);
      case (k)
         1:       return tw_q(3, tww);
         2:       return tw_q(2, tww);
         3:       return tw_q(1, tww);
         4:       return tw_q(0, tww);
         5:       return tw_q(1, tww);
         6:       return tw_q(2, tww);
         7:       return tw_q(3, tww);
         9:       return -tw_q(3, tww);
         default: return 0;
      endcase
   endfunction

   function automatic logic [3:0] digrev(input logic [3:0] a);
      return {a[1:0], a[3:2]};
   endfunction
endpackage

// File: rtl/fft_radix4_bf.sv
// Combinational 4-point butterfly; i_inv swaps the -j/+j rotation of legs 1/3.
module fft_radix4_bf #(
   parameter int W = 21
) (
   input  logic                i_inv,
   input  logic signed [W-1:0] i_re [4],
   input  logic signed [W-1:0] i_im [4],
   output logic signed [W-1:0] o_re [4],
   output logic signed [W-1:0] o_im [4]
);
   localparam int X = W + 2;

   logic signed [X-1:0] w_r [4];
   logic signed [X-1:0] w_i [4];
   logic signed [X-1:0] w_acr, w_aci, w_scr, w_sci;
   logic signed [X-1:0] w_bdr, w_bdi, w_sbr, w_sbi;
   logic signed [X-1:0] w_x0r, w_x0i, w_x2r, w_x2i;
   logic signed [X-1:0] w_pr, w_pi, w_nr, w_ni;

   always_comb begin
      for (int i = 0; i < 4; i++) begin
         w_r[i] = X'(i_re[i]);
         w_i[i] = X'(i_im[i]);
      end
      w_acr = w_r[0] + w_r[2];
      w_aci = w_i[0] + w_i[2];
      w_scr = w_r[0] - w_r[2];
      w_sci = w_i[0] - w_i[2];
      w_bdr = w_r[1] + w_r[3];
      w_bdi = w_i[1] + w_i[3];
      w_sbr = w_r[1] - w_r[3];
      w_sbi = w_i[1] - w_i[3];
      w_x0r = w_acr + w_bdr;
      w_x0i = w_aci + w_bdi;
      w_x2r = w_acr - w_bdr;
      w_x2i = w_aci - w_bdi;
      // p = a - jb - c + jd, n = a + jb - c - jd
      w_pr  = w_scr + w_sbi;
      w_pi  = w_sci - w_sbr;
      w_nr  = w_scr - w_sbi;
      w_ni  = w_sci + w_sbr;
   end

   assign o_re[0] = w_x0r[W-1:0];
   assign o_im[0] = w_x0i[W-1:0];
   assign o_re[2] = w_x2r[W-1:0];
   assign o_im[2] = w_x2i[W-1:0];
   assign o_re[1] = i_inv ? w_nr[W-1:0] : w_pr[W-1:0];
   assign o_im[1] = i_inv ? w_ni[W-1:0] : w_pi[W-1:0];
   assign o_re[3] = i_inv ? w_pr[W-1:0] : w_nr[W-1:0];
   assign o_im[3] = i_inv ? w_pi[W-1:0] : w_ni[W-1:0];
endmodule

// File: rtl/fft16_radix4_seq.sv
// Sequential 16-point radix-4 FFT/IFFT with one shared butterfly.
// FFT_OUT_DIGITREV_EN: emit bins in storage (digit-reversed) order.
module fft16_radix4_seq #(
   parameter int WIDTH = 16,
   parameter int TWW   = 16
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic signed [WIDTH-1:0] in_re,
   input  logic signed [WIDTH-1:0] in_im,
   input  logic                    inverse,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic signed [WIDTH+4:0] out_re,
   output logic signed [WIDTH+4:0] out_im,
   output logic [3:0]              out_idx,
   output logic                    out_last,
   output logic                    busy
);
   import fft16_pkg::*;

   localparam int OUTW = WIDTH + 5;
   localparam int PW   = OUTW + TWW + 1;
   localparam logic signed [PW-1:0] RND = PW'(2 ** (TWW - 3));

   state_t                 r_state;
   logic [3:0]             r_cnt, r_k, r_oidx;
   logic                   r_inv, r_in_ready, r_ov, r_last, r_busy;
   logic signed [OUTW-1:0] r_ore, r_oim;
   logic signed [OUTW-1:0] r_re [N];
   logic signed [OUTW-1:0] r_im [N];

   logic [3:0]             w_addr [RADIX];
   logic signed [OUTW-1:0] w_bi_re [RADIX];
   logic signed [OUTW-1:0] w_bi_im [RADIX];
   logic signed [OUTW-1:0] w_bo_re [RADIX];
   logic signed [OUTW-1:0] w_bo_im [RADIX];
   logic signed [OUTW-1:0] w_tr [RADIX];
   logic signed [OUTW-1:0] w_ti [RADIX];
   logic signed [TWW-1:0]  w_wr [RADIX];
   logic signed [TWW-1:0]  w_wi [RADIX];
   logic signed [PW-1:0]   w_pr [RADIX];
   logic signed [PW-1:0]   w_pi [RADIX];
   int                     w_k [RADIX];
   int                     w_c [RADIX];
   int                     w_s [RADIX];
   logic [3:0]             w_nk, w_raddr, w_nidx;

   always_comb begin
      for (int m = 0; m < RADIX; m++) begin
         if (r_state == STG2) w_addr[m] = 4'(4 * int'(r_cnt[1:0]) + m);
         else w_addr[m] = 4'(int'(r_cnt[1:0]) + 4 * m);
         w_bi_re[m] = r_re[w_addr[m]];
         w_bi_im[m] = r_im[w_addr[m]];
         // second stage uses index 0, i.e. an exact multiply by 1
         w_k[m]  = (r_state == STG1) ? int'(r_cnt[1:0]) * m : 0;
         w_c[m]  = tw_cos(w_k[m], TWW);
         w_s[m]  = tw_sin(w_k[m], TWW);
         w_wr[m] = TWW'(w_c[m]);
         w_wi[m] = r_inv ? TWW'(w_s[m]) : TWW'(-w_s[m]);
         w_pr[m] = PW'(w_bo_re[m]) * PW'(w_wr[m])
                 - PW'(w_bo_im[m]) * PW'(w_wi[m]) + RND;
         w_pi[m] = PW'(w_bo_re[m]) * PW'(w_wi[m])
                 + PW'(w_bo_im[m]) * PW'(w_wr[m]) + RND;
         w_pr[m] = w_pr[m] >>> (TWW - 2);
         w_pi[m] = w_pi[m] >>> (TWW - 2);
         w_tr[m] = w_pr[m][OUTW-1:0];
         w_ti[m] = w_pi[m][OUTW-1:0];
      end
   end

   fft_radix4_bf #(.W(OUTW)) u_bf (
      .i_inv (r_inv),
      .i_re  (w_bi_re),
      .i_im  (w_bi_im),
      .o_re  (w_bo_re),
      .o_im  (w_bo_im)
   );

   assign w_nk = r_ov ? r_k + 4'd1 : r_k;
`ifdef FFT_OUT_DIGITREV_EN
   assign w_raddr = w_nk;
   assign w_nidx  = digrev(w_nk);
`else
   assign w_raddr = digrev(w_nk);
   assign w_nidx  = w_nk;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state    <= IDLE;
         r_cnt      <= '0;
         r_k        <= '0;
         r_oidx     <= '0;
         r_inv      <= 1'b0;
         r_in_ready <= 1'b1;
         r_ov       <= 1'b0;
         r_last     <= 1'b0;
         r_busy     <= 1'b0;
         r_ore      <= '0;
         r_oim      <= '0;
         for (int i = 0; i < N; i++) begin
            r_re[i] <= '0;
            r_im[i] <= '0;
         end
      end else begin
         unique case (r_state)
            IDLE, LOAD: begin
               if (in_valid && r_in_ready) begin
                  r_re[r_cnt] <= OUTW'(in_re);
                  r_im[r_cnt] <= OUTW'(in_im);
                  if (r_state == IDLE) r_inv <= inverse;
                  if (r_cnt == 4'd15) begin
                     r_state    <= STG1;
                     r_in_ready <= 1'b0;
                     r_busy     <= 1'b1;
                     r_cnt      <= '0;
                  end else begin
                     r_state <= LOAD;
                     r_cnt   <= r_cnt + 4'd1;
                  end
               end
            end
            STG1, STG2: begin
               for (int m = 0; m < RADIX; m++) begin
                  r_re[w_addr[m]] <= w_tr[m];
                  r_im[w_addr[m]] <= w_ti[m];
               end
               if (r_cnt[1:0] == 2'd3) begin
                  r_cnt   <= '0;
                  r_k     <= '0;
                  r_state <= (r_state == STG1) ? STG2 : UNLOAD;
               end else begin
                  r_cnt <= r_cnt + 4'd1;
               end
            end
            UNLOAD: begin
               if (!r_ov || out_ready) begin
                  if (r_ov && r_k == 4'd15) begin
                     r_ov       <= 1'b0;
                     r_last     <= 1'b0;
                     r_busy     <= 1'b0;
                     r_in_ready <= 1'b1;
                     r_state    <= IDLE;
                  end else begin
                     r_ov   <= 1'b1;
                     r_k    <= w_nk;
                     r_oidx <= w_nidx;
                     r_last <= (w_nk == 4'd15);
                     r_ore  <= r_re[w_raddr];
                     r_oim  <= r_im[w_raddr];
                  end
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign in_ready  = r_in_ready;
   assign out_valid = r_ov;
   assign out_re    = r_ore;
   assign out_im    = r_oim;
   assign out_idx   = r_oidx;
   assign out_last  = r_last;
   assign busy      = r_busy;
endmodule

// File: tb/tb_fft16_radix4_seq.sv
// Directed, table-driven bench for fft16_radix4_seq (natural-order build).
module tb_fft16_radix4_seq;
   localparam int WIDTH = 16;
   localparam int OUTW  = WIDTH + 5;

   logic                   clk = 1'b0;
   logic                   rst = 1'b0;
   logic                   in_valid, in_ready, inverse;
   logic signed [WIDTH-1:0] in_re, in_im;
   logic                   out_valid, out_ready, out_last, busy;
   logic signed [OUTW-1:0] out_re, out_im;
   logic [3:0]             out_idx;

   always #5 clk = ~clk;

   fft16_radix4_seq #(.WIDTH(WIDTH), .TWW(16)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_re     (in_re),
      .in_im     (in_im),
      .inverse   (inverse),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_re    (out_re),
      .out_im    (out_im),
      .out_idx   (out_idx),
      .out_last  (out_last),
      .busy      (busy)
   );

   typedef struct {
      int pat;
      bit inv;
      int k;
      int er;
      int ei;
      int tol;
   } vec_t;

   vec_t vq[$];
   int   n_err = 0;
   int   n_chk = 0;
   int   cap_re[16];
   int   cap_im[16];

   task automatic chk(input string nm, input longint act,
                      input longint exp, input int tol);
      n_chk++;
      if (act > exp + tol || act < exp - tol) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
      end
   endtask

   function automatic void add(input int pat, input bit inv, input int k,
                               input int er, input int ei, input int tol);
      vec_t v;
      v.pat = pat; v.inv = inv; v.k = k;
      v.er = er; v.ei = ei; v.tol = tol;
      vq.push_back(v);
   endfunction

   // 0 impulse, 1 DC, 2 shifted impulse, 3 full scale
   function automatic void samp(input int pat, input int n,
                                output int re, output int im);
      re = 0;
      im = 0;
      case (pat)
         0: if (n == 0) re = 1000;
         1: re = 100;
         2: if (n == 1) re = 1000;
         default: begin re = -32768; im = -32768; end
      endcase
   endfunction

   task automatic run_frame(input int pat, input bit inv,
                            input bit stall, input int stop_at);
      int re, im, t;
      for (int k = 0; k < 16; k++) begin
         cap_re[k] = 12345678;
         cap_im[k] = 12345678;
      end
      for (int n = 0; n < 16; n++) begin
         samp(pat, n, re, im);
         in_re    = WIDTH'(re);
         in_im    = WIDTH'(im);
         inverse  = (n == 0) ? inv : ~inv;
         in_valid = 1'b1;
         t = 0;
         while (!in_ready && t < 100) begin
            @(posedge clk); #1; t++;
         end
         if (t >= 100) begin
            chk("in_ready timeout", 0, 1, 0);
            in_valid = 1'b0;
            return;
         end
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      chk("in_ready after load", in_ready, 0, 0);
      chk("busy after load", busy, 1, 0);
      t = 0;
      while (!out_valid && t < 100) begin
         @(posedge clk); #1; t++;
      end
      chk("first out latency", t, 9, 0);
      for (int k = 0; k < 16; k++) begin
         t = 0;
         while (!out_valid && t < 100) begin
            @(posedge clk); #1; t++;
         end
         if (!out_valid) begin
            chk("out_valid timeout", 0, 1, 0);
            return;
         end
         chk($sformatf("out_idx at %0d", k), out_idx, k, 0);
         chk($sformatf("out_last at %0d", k), out_last, (k == 15), 0);
         chk($sformatf("in_ready unload %0d", k), in_ready, 0, 0);
         cap_re[k] = int'(out_re);
         cap_im[k] = int'(out_im);
         if (k == stop_at) begin
            rst = 1'b0;
            #1;
            chk("out_valid async reset", out_valid, 0, 0);
            @(negedge clk);
            rst = 1'b1;
            @(posedge clk); #1;
            chk("in_ready after reset", in_ready, 1, 0);
            chk("busy after reset", busy, 0, 0);
            return;
         end
         if (stall) begin
            out_ready = 1'b0;
            @(posedge clk); #1;
            chk($sformatf("hold valid %0d", k), out_valid, 1, 0);
            chk($sformatf("hold re %0d", k), out_re, cap_re[k], 0);
            chk($sformatf("hold im %0d", k), out_im, cap_im[k], 0);
            chk($sformatf("hold idx %0d", k), out_idx, k, 0);
            out_ready = 1'b1;
         end
         @(posedge clk); #1;
      end
      chk("out_valid after last", out_valid, 0, 0);
      chk("in_ready after last", in_ready, 1, 0);
      chk("busy after last", busy, 0, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int cur_pat;
      bit cur_inv;
      in_valid  = 1'b0;
      in_re     = '0;
      in_im     = '0;
      inverse   = 1'b0;
      out_ready = 1'b1;

      for (int k = 0; k < 16; k++) add(0, 1'b0, k, 1000, 0, 0);
      for (int k = 0; k < 16; k++) add(1, 1'b0, k, (k == 0) ? 1600 : 0, 0, 0);
      add(2, 1'b0, 0, 1000, 0, 0);
      add(2, 1'b0, 1, 924, -383, 1);
      add(2, 1'b0, 2, 707, -707, 1);
      add(2, 1'b0, 4, 0, -1000, 0);
      add(2, 1'b0, 8, -1000, 0, 0);
      add(2, 1'b0, 12, 0, 1000, 0);
      add(2, 1'b1, 2, 707, 707, 1);
      add(2, 1'b1, 4, 0, 1000, 0);
      add(2, 1'b1, 8, -1000, 0, 0);
      add(2, 1'b1, 12, 0, -1000, 0);
      for (int k = 0; k < 16; k++)
         add(3, 1'b0, k, (k == 0) ? -524288 : 0, (k == 0) ? -524288 : 0, 0);

      repeat (3) @(posedge clk);
      #1;
      chk("reset in_ready", in_ready, 1, 0);
      chk("reset out_valid", out_valid, 0, 0);
      chk("reset busy", busy, 0, 0);
      chk("reset out_last", out_last, 0, 0);
      chk("reset out_re", out_re, 0, 0);
      chk("reset out_idx", out_idx, 0, 0);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk); #1;

      cur_pat = -1;
      cur_inv = 1'b0;
      for (int i = 0; i < vq.size(); i++) begin
         if (vq[i].pat != cur_pat || vq[i].inv != cur_inv) begin
            run_frame(vq[i].pat, vq[i].inv, vq[i].pat == 1, 99);
            cur_pat = vq[i].pat;
            cur_inv = vq[i].inv;
         end
         chk($sformatf("p%0d inv%0d bin%0d re", vq[i].pat, vq[i].inv, vq[i].k),
             cap_re[vq[i].k], vq[i].er, vq[i].tol);
         chk($sformatf("p%0d inv%0d bin%0d im", vq[i].pat, vq[i].inv, vq[i].k),
             cap_im[vq[i].k], vq[i].ei, vq[i].tol);
      end

      run_frame(1, 1'b0, 1'b0, 5);
      run_frame(1, 1'b0, 1'b0, 99);
      chk("post-reset bin0 re", cap_re[0], 1600, 0);
      chk("post-reset bin0 im", cap_im[0], 0, 0);
      chk("post-reset bin5 re", cap_re[5], 0, 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule

// File: doc/fft16_radix4_seq.md
Name: fft16_radix4_seq

Overview:
Sequential, streaming successor to the fully parallel 16-point radix-4 FFT top. It accepts complex samples over a valid/ready stream and stores one 16-sample frame. A single shared radix-4 butterfly runs both stages in 8 cycles. The block then emits the 16 bins in natural order over a valid/ready stream. It supports forward and inverse transforms, selectable per frame, and sits between the sample front-end and the spectral post-processing.

Parameters:
- WIDTH, 16: input sample width, signed two's complement, per real/imag component.
- TWW, 16: twiddle width, signed Q2.(TWW-2); 1.0 = 2^(TWW-2).
- OUTW, WIDTH+5 (localparam, not overridable): internal word and output width. Guarantees no overflow for any input.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  input sample valid.
- in_ready  out  1  block can accept a sample.
- in_re  in  WIDTH  input sample, real part.
- in_im  in  WIDTH  input sample, imaginary part.
- inverse  in  1  1 = IFFT; sampled with the frame's first accepted sample.
- out_valid  out  1  output bin valid.
- out_ready  in  1  downstream accepts the bin.
- out_re  out  OUTW  bin, real part.
- out_im  out  OUTW  bin, imaginary part.
- out_idx  out  4  bin index k of the current output.
- out_last  out  1  high with the frame's final output bin.
- busy  out  1  high in STG1, STG2 and UNLOAD.

Behaviour:
- Reset (rst=0, async): state=IDLE, in_ready=1, and all other outputs 0. A reset mid-frame discards the frame.
- FSM states: IDLE, LOAD, STG1, STG2, UNLOAD.
- IDLE→LOAD on the first in_valid&in_ready; that handshake latches inverse into inv_q.
- LOAD: sample n (n = handshake count 0..15) is written to buffer[n], sign-extended to OUTW. After the 16th handshake: STG1, in_ready=0.
- STG1: 4 cycles, q=0..3.
  - Butterfly inputs: buffer[q], [q+4], [q+8], [q+12].
  - Output m (0..3) is multiplied by W16^(q·m), where W=e^(-j2π/16), conjugated when inv_q=1.
  - Results are written back to [q+4m].
- STG2: 4 cycles, g=0..3.
  - Butterfly inputs: buffer[4g..4g+3]; twiddles are all 1.
  - Results written in place; bin k ends up at address 4·(k mod 4)+(k div 4).
- Butterfly: forward uses the -j rotation for legs 1/3; inverse uses +j. The inverse is unscaled (no 1/16).
- Twiddle multiply:
  - Full-precision complex product, then add 2^(TWW-3), then arithmetic shift right by TWW-2.
  - Result is truncated to OUTW; this cannot overflow by construction.
- Latency: the 16th input handshake occurs on edge T; the first out_valid=1 appears after edge T+9.
- UNLOAD:
  - Emits k=0..15, reading the digit-reversed address, with out_idx=k.
  - out_re, out_im and out_idx stay stable while out_valid&!out_ready.
  - out_last=1 only for k=15.
  - After the k=15 handshake: out_valid=0, state=IDLE, and in_ready=1 on the next cycle.
- in_ready=0 during STG1, STG2 and UNLOAD; input is never accepted while the output is pending.
- in_valid with in_ready=0 has no effect. inverse changes mid-frame are ignored.
- out_ready asserted with out_valid=0 has no effect.
- No other reset or abort path; the frame counter wraps only via a state transition.

Optional Feature:
- Macro FFT_OUT_DIGITREV_EN.
- Defined: UNLOAD reads sequential addresses 0..15 (digit-reversed bin order). out_idx reports the true bin index 4·(a mod 4)+(a div 4), so addr 1 gives out_idx 4. out_last still marks the 16th output.
- Undefined: natural-order output as above.
- Latency and handshake are identical in both builds.

Decomposition:
- Shared package fft16_pkg holds:
  - the state enum;
  - localparams N=16 and RADIX=4;
  - the twiddle constant tables W16^k for k=0..9 (cos/sin, Q2.14 for TWW=16), generated via a function of TWW;
  - the digit-reverse address function.
- Sub-module fft_radix4_bf: combinational 4-point butterfly, parameter W and an inverse select input. Instantiated once with W=OUTW and shared by both stages.

Test Plan:
- Impulse: x[0]=1000+0j, rest 0, inverse=0 → all 16 bins (1000,0). First out_valid exactly 9 cycles after the 16th handshake.
- DC: all x=100+0j → bin0=(1600,0); bins 1..15=(0,0).
- Shifted impulse: x[1]=1000, inverse=0 → bin4=(0,-1000), bin2=(707,-707) ±1, bin8=(-1000,0). Same frame with inverse=1 → bin4=(0,1000).
- Full scale: all x=(-32768,-32768) → bin0=(-524288,-524288), no wrap; other bins 0.
- Backpressure: out_ready alternates 1/0 → outputs held stable while stalled; 16 outputs with out_idx 0..15 in order; out_last only on 15; in_ready=0 until the cycle after the last handshake.
- Reset mid-UNLOAD (rst=0 at bin 5) → out_valid=0 immediately, in_ready=1 after release; the next DC frame yields bin0=1600.
